// File: rtl/fnd_scan_sequencer.sv
// fnd_scan_sequencer
// Time-multiplexes one 4-bit add/subtract datapath and one FND decoder across
// four display digits. Each digit is lit for ON_CYCLES cycles, followed by
// BLANK_CYCLES cycles of blanking. The per-digit carry/borrow returned by the
// adder is captured on the last lit cycle of that digit.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_en                scan enable (low forces IDLE, digit 0)
//   i_load              one-cycle request to capture i_a/i_b/i_mode
//   i_a, i_b            operands, nibble k belongs to digit k
//   i_mode              0 = add, 1 = subtract
//   i_carry             carry/borrow from the external adder
//   o_a, o_b, o_mode    operands and mode presented to the adder
//   o_digitSelect       digit index to the decoder
//   o_en                decoder enable (digit lit)
//   o_carry             captured carry/borrow per digit
//   o_loadPending       load accepted, waiting for a frame boundary
//   o_frameDone         one-cycle pulse when digit 3's blank ends
module fnd_scan_sequencer #(
  parameter int ON_CYCLES    = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_mode,
  input  logic        i_carry,
  output logic [3:0]  o_a,
  output logic [3:0]  o_b,
  output logic        o_mode,
  output logic [1:0]  o_digitSelect,
  output logic        o_en,
  output logic [3:0]  o_carry,
  output logic        o_loadPending,
  output logic        o_frameDone
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [3:0]       carry_q, carry_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      app_a_q, app_a_d;
  logic [15:0]      app_b_q, app_b_d;
  logic             app_mode_q, app_mode_d;
  logic [15:0]      pend_a_q, pend_a_d;
  logic [15:0]      pend_b_q, pend_b_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pend_q, pend_d;
  logic             wrap;
  logic             apply_ok;

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    frame_done_d = 1'b0;
    app_a_d      = app_a_q;
    app_b_d      = app_b_q;
    app_mode_d   = app_mode_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    pend_mode_d  = pend_mode_q;
    pend_d       = pend_q;
    wrap         = 1'b0;

    if (!i_en) begin
      state_d = IDLE;
      digit_d = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACTIVE;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
        ACTIVE: begin
          if (cnt_q == ON_LAST) begin
            // Last lit cycle: the adder output reflects this digit's operands.
            carry_d[digit_q] = i_carry;
            state_d          = BLANK;
            cnt_d            = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              frame_done_d = 1'b1;
              wrap         = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end

    // Operands only change between frames (or while idle) so all four digits
    // of one frame come from the same operand set.
    apply_ok = wrap || (state_q == IDLE);

    if (i_load) begin
      pend_a_d    = i_a;
      pend_b_d    = i_b;
      pend_mode_d = i_mode;
    end

    if (apply_ok) begin
      // A load arriving exactly on the boundary bypasses the pending stage.
      if (i_load) begin
        app_a_d    = i_a;
        app_b_d    = i_b;
        app_mode_d = i_mode;
      end else if (pend_q) begin
        app_a_d    = pend_a_q;
        app_b_d    = pend_b_q;
        app_mode_d = pend_mode_q;
      end
      pend_d = 1'b0;
    end else if (i_load) begin
      pend_d = 1'b1;
    end

    en_d = (state_d == ACTIVE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      en_q         <= 1'b0;
      carry_q      <= 4'd0;
      frame_done_q <= 1'b0;
      app_a_q      <= 16'd0;
      app_b_q      <= 16'd0;
      app_mode_q   <= 1'b0;
      pend_a_q     <= 16'd0;
      pend_b_q     <= 16'd0;
      pend_mode_q  <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      carry_q      <= carry_d;
      frame_done_q <= frame_done_d;
      app_a_q      <= app_a_d;
      app_b_q      <= app_b_d;
      app_mode_q   <= app_mode_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      pend_mode_q  <= pend_mode_d;
      pend_q       <= pend_d;
    end
  end

  assign o_a           = app_a_q[4*digit_q +: 4];
  assign o_b           = app_b_q[4*digit_q +: 4];
  assign o_mode        = app_mode_q;
  assign o_digitSelect = digit_q;
  assign o_en          = en_q;
  assign o_carry       = carry_q;
  assign o_loadPending = pend_q;
  assign o_frameDone   = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_sequencer.sv
// Directed testbench for fnd_scan_sequencer with ON_CYCLES=4, BLANK_CYCLES=2
// (6 cycles per digit, 24 per frame). A behavioural adder drives i_carry.
module tb_fnd_scan_sequencer;

  logic        clk = 1'b0;
  logic        i_reset, i_en, i_load, i_mode, i_carry;
  logic [15:0] i_a, i_b;
  logic [3:0]  o_a, o_b, o_carry;
  logic        o_mode, o_en, o_loadPending, o_frameDone;
  logic [1:0]  o_digitSelect;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  // Behavioural adder: carry-out for add, borrow (a < b) for subtract.
  assign i_carry = o_mode ? (o_a < o_b) : (({1'b0, o_a} + {1'b0, o_b}) > 5'd15);

  fnd_scan_sequencer #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_en(i_en), .i_load(i_load),
    .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_carry(i_carry),
    .o_a(o_a), .o_b(o_b), .o_mode(o_mode), .o_digitSelect(o_digitSelect),
    .o_en(o_en), .o_carry(o_carry), .o_loadPending(o_loadPending),
    .o_frameDone(o_frameDone)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] old_a;
    logic [15:0] new_a;
    int p;

    i_reset = 1'b1; i_en = 1'b0; i_load = 1'b0;
    i_a = 16'd0; i_b = 16'd0; i_mode = 1'b0;

    // Reset / idle
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_a", 16'(o_a), 16'h0);
    chk("rst_b", 16'(o_b), 16'h0);
    chk("rst_mode", 16'(o_mode), 16'h0);
    chk("rst_dig", 16'(o_digitSelect), 16'h0);
    chk("rst_carry", 16'(o_carry), 16'h0);
    chk("rst_pend", 16'(o_loadPending), 16'h0);
    chk("rst_fd", 16'(o_frameDone), 16'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_en", 16'(o_en), 16'h0);
      chk("idle_dig", 16'(o_digitSelect), 16'h0);
    end
    $display("reset/idle checked");

    // Load in IDLE applies after one cycle
    i_load = 1'b1; i_a = 16'h4321; i_b = 16'h1111; i_mode = 1'b0;
    tick();
    i_load = 1'b0;
    chk("idle_load_a", 16'(o_a), 16'h1);
    chk("idle_load_b", 16'(o_b), 16'h1);
    chk("idle_load_pend", 16'(o_loadPending), 16'h0);
    $display("idle load a=4321 b=1111 add");

    // Scan sequence + add operands
    i_en = 1'b1;
    for (int t = 1; t <= 49; t++) begin
      int q;
      tick();
      q = (t - 1) % 24;
      chk("scan_dig", 16'(o_digitSelect), 16'(q / 6));
      chk("scan_en", 16'(o_en), 16'((q % 6) < 4));
      chk("scan_fd", 16'(o_frameDone), 16'((t > 1) && (q == 0)));
      chk("add_a", 16'(o_a), 16'((q / 6) + 1));
      chk("add_b", 16'(o_b), 16'h1);
    end
    chk("add_carry", 16'(o_carry), 16'h0);
    $display("scan sequence 2 frames checked, carry=%b", o_carry);

    // Subtract: loaded mid-scan (p=0), applied at next wrap
    i_load = 1'b1; i_a = 16'h0F00; i_b = 16'h0101; i_mode = 1'b1;
    tick();
    i_load = 1'b0;
    chk("sub_pend", 16'(o_loadPending), 16'h1);
    chk("sub_mode_old", 16'(o_mode), 16'h0);
    for (int i = 0; i < 23; i++) tick();
    chk("sub_fd", 16'(o_frameDone), 16'h1);
    chk("sub_pend_clr", 16'(o_loadPending), 16'h0);
    chk("sub_mode", 16'(o_mode), 16'h1);
    chk("sub_a0", 16'(o_a), 16'h0);
    chk("sub_b0", 16'(o_b), 16'h1);
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (i == 12) begin
        chk("sub_a2", 16'(o_a), 16'hF);
        chk("sub_b2", 16'(o_b), 16'h1);
      end
    end
    chk("sub_carry", 16'(o_carry), 16'b0001);
    $display("subtract a=0F00 b=0101 carry=%b", o_carry);

    // Mid-frame load: two loads during digit 1, last one wins at the wrap
    for (int i = 0; i < 6; i++) tick();
    chk("mid_dig1", 16'(o_digitSelect), 16'h1);
    i_load = 1'b1; i_a = 16'hAAAA; i_b = 16'h0B0B; i_mode = 1'b0;
    tick();
    i_a = 16'h5555;
    tick();
    i_load = 1'b0;
    p = 8;
    old_a = 16'h0F00;
    new_a = 16'h5555;
    chk("mid_pend", 16'(o_loadPending), 16'h1);
    while (p < 24) begin
      tick();
      p++;
      if (p < 24) begin
        chk("mid_pend_hold", 16'(o_loadPending), 16'h1);
        chk("mid_old_a", 16'(o_a), 16'(old_a[4*(p/6) +: 4]));
      end
    end
    chk("mid_fd", 16'(o_frameDone), 16'h1);
    chk("mid_pend_clr", 16'(o_loadPending), 16'h0);
    chk("mid_new_a", 16'(o_a), 16'(new_a[3:0]));
    chk("mid_new_b", 16'(o_b), 16'hB);
    chk("mid_mode", 16'(o_mode), 16'h0);
    for (int i = 0; i < 24; i++) tick();
    chk("mid_carry", 16'(o_carry), 16'b0101);
    $display("mid-frame load 5555+0B0B carry=%b", o_carry);

    // Disable during digit 2
    for (int i = 0; i < 12; i++) tick();
    chk("dis_dig2", 16'(o_digitSelect), 16'h2);
    i_en = 1'b0;
    tick();
    chk("dis_en", 16'(o_en), 16'h0);
    chk("dis_dig", 16'(o_digitSelect), 16'h0);
    chk("dis_carry", 16'(o_carry), 16'b0101);
    chk("dis_a", 16'(o_a), 16'h5);
    $display("disable mid-scan carry=%b", o_carry);

    // Reset while a load is pending
    i_en = 1'b1;
    tick();
    i_load = 1'b1; i_a = 16'h1234; i_b = 16'h4321; i_mode = 1'b1;
    tick();
    i_load = 1'b0;
    chk("rp_pend", 16'(o_loadPending), 16'h1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rp_pend_clr", 16'(o_loadPending), 16'h0);
    chk("rp_carry", 16'(o_carry), 16'h0);
    chk("rp_en", 16'(o_en), 16'h0);
    chk("rp_a", 16'(o_a), 16'h0);
    chk("rp_mode", 16'(o_mode), 16'h0);
    $display("reset with pending load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
